i2s_rx: RTL and testbench

I2S serial receiver that sits directly upstream of the audio low-pass FIR stage. It deserialises the codec's BCLK/LRCK/SDATA stream into signed 16-bit left/right samples. It produces a one-cycle `sample_valid` strobe per stereo frame, which the filter uses as its `clk_enable`. All I2S pins are asynchronous to `clk`; they are synchronised and edge-detected inside the block.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sync.sv | 56 +++++
 rtl/i2s_rx.sv | 179 +++++++++++++++++
 tb/tb_i2s_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S receiver.
//   I2S_DATA_W_DEFAULT : default sample width in bits
//   i2s_state_t        : receiver FSM states (IDLE, ALIGN, SHIFT)
package i2s_pkg;

  localparam int I2S_DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: N-stage synchroniser for one asynchronous pin, with edge detect.
//   clk     in  : system clock
//   reset_n in  : asynchronous active-low reset, clears every flop
//   din     in  : asynchronous input pin
//   level   out : synchronised level
//   rise    out : one-cycle pulse when the synchronised level goes 0->1
//   fall    out : one-cycle pulse when the synchronised level goes 1->0
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              dly_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Extra delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_reg <= 1'b0;
    end else begin
      dly_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~dly_reg;
  assign fall  = ~sync_reg[STAGES-1] & dly_reg;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial receiver producing signed stereo samples.
//   clk          in  : system clock (>= 6x BCLK)
//   reset_n      in  : asynchronous active-low reset
//   en           in  : receiver enable; low returns to IDLE, outputs hold
//   i2s_bclk     in  : serial bit clock (async)
//   i2s_lrck     in  : word select, 0 = left, 1 = right (async)
//   i2s_sdata    in  : serial data, MSB first (async)
//   left_out     out : last complete left sample
//   right_out    out : last complete right sample
//   sample_valid out : one-cycle strobe when left_out/right_out update
//   frame_err    out : one-cycle pulse on a word shorter than DATA_W bits
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic bclk_rise;
  logic lrck_s;
  logic sdata_s;
  logic bclk_level_unused, bclk_fall_unused;
  logic lrck_rise_unused, lrck_fall_unused;
  logic sdata_rise_unused, sdata_fall_unused;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (i2s_bclk),
    .level   (bclk_level_unused),
    .rise    (bclk_rise),
    .fall    (bclk_fall_unused)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (i2s_lrck),
    .level   (lrck_s),
    .rise    (lrck_rise_unused),
    .fall    (lrck_fall_unused)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (i2s_sdata),
    .level   (sdata_s),
    .rise    (sdata_rise_unused),
    .fall    (sdata_fall_unused)
  );

  i2s_state_t        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] left_hold_reg;
  logic              lrck_prev_reg;
  logic              lrck_primed_reg;
  logic              have_left_reg;
  logic [DATA_W-1:0] left_out_reg;
  logic [DATA_W-1:0] right_out_reg;
  logic              sample_valid_reg;
  logic              frame_err_reg;

  // Word state after this bit slot: bits beyond DATA_W are ignored and the
  // counter saturates, so wide slots need no special handling.
  logic              bit_room;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  bit_cnt_next;
  logic              short_word;
  logic [DATA_W-1:0] word_aligned;
  logic              boundary;

  assign bit_room     = (bit_cnt_reg < CNT_FULL);
  assign shift_next   = bit_room ? {shift_reg[DATA_W-2:0], sdata_s} : shift_reg;
  assign bit_cnt_next = bit_room ? bit_cnt_reg + CNT_W'(1) : bit_cnt_reg;
  assign short_word   = (bit_cnt_next < CNT_FULL);
  // A short word is left-justified with zero fill; a full word shifts by 0.
  assign word_aligned = shift_next << (CNT_FULL - bit_cnt_next);
  assign boundary     = lrck_s ^ lrck_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      left_hold_reg    <= '0;
      lrck_prev_reg    <= 1'b0;
      lrck_primed_reg  <= 1'b0;
      have_left_reg    <= 1'b0;
      left_out_reg     <= '0;
      right_out_reg    <= '0;
      sample_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;

      // LRCK history is tracked in every state so a relock after an enable
      // drop sees the real next boundary. The primed flag stops the reset
      // value of lrck_prev from faking a boundary when we start mid-word.
      if (bclk_rise) begin
        lrck_prev_reg   <= lrck_s;
        lrck_primed_reg <= 1'b1;
      end

      if (!en) begin
        state_reg     <= IDLE;
        bit_cnt_reg   <= '0;
        shift_reg     <= '0;
        have_left_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bclk_rise && lrck_primed_reg && boundary) begin
              state_reg <= ALIGN;
            end
          end

          // The boundary slot carried the last bit of the discarded word; the
          // next bclk_rise is the MSB. BCLK phases are >= 3 clk, so moving to
          // SHIFT one clk later cannot miss that rise.
          ALIGN: begin
            state_reg     <= SHIFT;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            have_left_reg <= 1'b0;
          end

          SHIFT: begin
            if (bclk_rise) begin
              if (boundary) begin
                frame_err_reg <= short_word;
                if (lrck_s) begin
                  left_hold_reg <= word_aligned;
                  have_left_reg <= 1'b1;
                end else begin
                  if (have_left_reg) begin
                    left_out_reg     <= left_hold_reg;
                    right_out_reg    <= word_aligned;
                    sample_valid_reg <= 1'b1;
                  end
                  have_left_reg <= 1'b0;
                end
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
              end else begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_next;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign left_out     = left_out_reg;
  assign right_out    = right_out_reg;
  assign sample_valid = sample_valid_reg;
  assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stimulus with a slot-level reference model and a
// scoreboard; a monitor pops expected samples/errors when the DUT strobes.
module tb_i2s_rx;

  localparam int DATA_W = 16;

  localparam int ACT_NONE    = 0;
  localparam int ACT_EN_DROP = 1;
  localparam int ACT_RST_ON  = 2;
  localparam int ACT_RST_OFF = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              en = 1'b1;
  logic              i2s_bclk = 1'b0;
  logic              i2s_lrck = 1'b0;
  logic              i2s_sdata = 1'b0;
  logic [DATA_W-1:0] left_out;
  logic [DATA_W-1:0] right_out;
  logic              sample_valid;
  logic              frame_err;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          id;
  } frame_t;

  frame_t      exp_q[$];
  int          err_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          in_session = 1'b0;
  bit          left_pending = 1'b0;
  logic [15:0] left_val = '0;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;
  logic        prev_bit = 1'b0;
  int          slot_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One BCLK period: LRCK/SDATA change while BCLK is low, DUT samples on rise.
  task automatic tx_period(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrck  = lr;
    i2s_sdata = d;
    #($urandom_range(3, 5) * 10);
    i2s_bclk = 1'b1;
    #($urandom_range(3, 5) * 10);
  endtask

  task automatic do_action(input int act);
    if (act == ACT_EN_DROP) begin
      en = 1'b0;
      #100;
      chk("hold_left", 32'(left_out), 32'(last_l));
      chk("hold_right", 32'(right_out), 32'(last_r));
      en = 1'b1;
    end else if (act == ACT_RST_ON) begin
      reset_n = 1'b0;
      in_session = 1'b0;
      #1;
      chk("rst_left", 32'(left_out), 32'd0);
      chk("rst_right", 32'(right_out), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      last_l = '0;
      last_r = '0;
      #9;
    end else if (act == ACT_RST_OFF) begin
      reset_n = 1'b1;
      in_session = 1'b1;
    end
  endtask

  // Sends one slot of n bit-clocks; slot bit i is bits32[31-i]. Because of
  // the one-bit I2S delay, bit i goes out in period i+1 (the last bit lands in
  // the first period of the following slot). The model then decides from the
  // slot as a whole what the receiver must report.
  task automatic tx_slot(input logic lr, input int n, input logic [31:0] bits32,
                         input int act, input int act_at);
    bit          cap;
    int          k;
    logic [15:0] mask;
    logic [15:0] expw;
    frame_t      f;
    cap = in_session;
    for (int i = 0; i < n; i++) begin
      tx_period(lr, prev_bit);
      prev_bit = bits32[31-i];
      if (act != ACT_NONE && i == act_at) begin
        do_action(act);
        cap = 1'b0;
      end
    end
    if (cap) begin
      k    = (n < 16) ? n : 16;
      mask = 16'hFFFF;
      expw = bits32[31:16] & ~(mask >> k);
      if (n < 16) err_q.push_back(slot_id);
      if (lr == 1'b0) begin
        left_pending = 1'b1;
        left_val     = expw;
      end else begin
        if (left_pending) begin
          f.l  = left_val;
          f.r  = expw;
          f.id = slot_id;
          exp_q.push_back(f);
          last_l = left_val;
          last_r = expw;
        end
        left_pending = 1'b0;
      end
    end else begin
      left_pending = 1'b0;
    end
    slot_id++;
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return $urandom_range(6, 15);
    if (r < 6) return 16;
    return $urandom_range(17, 32);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got L=%h R=%h, required no strobe", left_out, right_out);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk($sformatf("left_out slot%0d", f.id), 32'(left_out), 32'(f.l));
          chk($sformatf("right_out slot%0d", f.id), 32'(right_out), 32'(f.r));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_err: got 1, required 0");
        end else begin
          int id;
          id = err_q.pop_front();
          chk($sformatf("frame_err slot%0d", id), 32'(frame_err), 32'd1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset_n = 1'b0;
    #11;
    chk("init_left", 32'(left_out), 32'd0);
    chk("init_right", 32'(right_out), 32'd0);
    chk("init_valid", 32'(sample_valid), 32'd0);
    chk("init_ferr", 32'(frame_err), 32'd0);

    // Reset released in the middle of a right word.
    tx_slot(1'b1, 16, $urandom, ACT_RST_OFF, 6);
    // Basic frame.
    tx_slot(1'b0, 16, {16'h1234, 16'h0000}, ACT_NONE, 0);
    tx_slot(1'b1, 16, {16'hFEDC, 16'h0000}, ACT_NONE, 0);
    // Wide 32-bit slots.
    tx_slot(1'b0, 32, {16'h8000, 16'hFFFF}, ACT_NONE, 0);
    tx_slot(1'b1, 32, {16'h7FFF, 16'h0000}, ACT_NONE, 0);
    // Short left word.
    tx_slot(1'b0, 12, {16'hABC0, 16'h0000}, ACT_NONE, 0);
    tx_slot(1'b1, 16, {16'h0001, 16'h0000}, ACT_NONE, 0);
    // Short right word: strobe and error together.
    tx_slot(1'b0, 16, $urandom, ACT_NONE, 0);
    tx_slot(1'b1, 10, $urandom, ACT_NONE, 0);
    // Random frames.
    for (int f = 0; f < 16; f++) begin
      tx_slot(1'b0, pick_len(), $urandom, ACT_NONE, 0);
      tx_slot(1'b1, pick_len(), $urandom, ACT_NONE, 0);
    end
    // Enable drop mid left word, then relock.
    tx_slot(1'b0, 16, $urandom, ACT_EN_DROP, 6);
    tx_slot(1'b1, 16, $urandom, ACT_NONE, 0);
    tx_slot(1'b0, 16, $urandom, ACT_NONE, 0);
    tx_slot(1'b1, 16, $urandom, ACT_NONE, 0);
    // Async reset while shifting, released mid right word.
    tx_slot(1'b0, 16, $urandom, ACT_RST_ON, 5);
    tx_slot(1'b1, 16, $urandom, ACT_RST_OFF, 7);
    for (int f = 0; f < 4; f++) begin
      tx_slot(1'b0, pick_len(), $urandom, ACT_NONE, 0);
      tx_slot(1'b1, pick_len(), $urandom, ACT_NONE, 0);
    end
    // Trailing slot completes the final right word.
    tx_slot(1'b0, 16, $urandom, ACT_NONE, 0);
    #500;
    chk("pending_samples", 32'(exp_q.size()), 32'd0);
    chk("pending_errors", 32'(err_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
